// File: rtl/shift_tick_ctrl_pkg.sv
// shift_tick_pkg: shared types and default constants for the shift_tick_ctrl
// input-conditioning / step-timing stage.
//   shift_state_t    FSM state encoding (IDLE = 0, RUN = 1, PAUSE = 2)
//   DEB_CYCLES_DEF   default debounce window (10 ms at 50 MHz)
//   STEP_CYCLES_DEF  default step period (0.25 s at 50 MHz)
package shift_tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } shift_state_t;

    localparam int unsigned DEB_CYCLES_DEF  = 500000;
    localparam int unsigned STEP_CYCLES_DEF = 12500000;

endpackage

// File: rtl/shift_tick_ctrl_if.sv
// shift_tick_ctrl_if: board-side inputs and shift-core-side outputs of
// shift_tick_ctrl.
//   sw_run_i      raw SW[0], 1 = run enabled
//   sw_dir_i      raw SW[1], direction request
//   key_pause_ni  raw KEY[1], active-low pause toggle
//   step_o        one-cycle shift strobe
//   dir_o         direction qualifying step_o
//   state_o       FSM state
// Modports: master = board/stimulus side, slave = shift_tick_ctrl.
interface shift_tick_ctrl_if;
    import shift_tick_pkg::*;

    logic         sw_run_i;
    logic         sw_dir_i;
    logic         key_pause_ni;
    logic         step_o;
    logic         dir_o;
    shift_state_t state_o;

    modport master (
        output sw_run_i, sw_dir_i, key_pause_ni,
        input  step_o, dir_o, state_o
    );

    modport slave (
        input  sw_run_i, sw_dir_i, key_pause_ni,
        output step_o, dir_o, state_o
    );

endinterface

// File: rtl/shift_tick_ctrl_debounce_sync.sv
// debounce_sync: 1-bit 2-FF synchronizer followed by a debouncer.
//   clk_i     system clock
//   reset_ni  asynchronous active-low reset
//   raw_i     raw asynchronous board input
//   db_o      synchronized, debounced value
// Parameters: RST_VAL (idle level of the input), DEB_CYCLES (stability window).
// Macro SHIFT_TICK_DEBOUNCE_EN: defined = counter-based debouncer,
// undefined = db_o follows the synchronizer directly (DEB_CYCLES ignored).
module debounce_sync
    import shift_tick_pkg::*;
#(
    parameter logic        RST_VAL    = 1'b0,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic raw_i,
    output logic db_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

`ifdef SHIFT_TICK_DEBOUNCE_EN
    localparam int unsigned          CW      = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0]        DEB_MAX = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          db_q;

    // Counter only runs while the synchronized value disagrees; any agreeing
    // cycle restarts the window, so short glitches never reach db_q.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
            db_q  <= RST_VAL;
        end else if (sync_q == db_q) begin
            cnt_q <= '0;
        end else if (cnt_q == DEB_MAX) begin
            cnt_q <= '0;
            db_q  <= sync_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign db_o = db_q;
`else
    assign db_o = sync_q;
`endif

endmodule

// File: rtl/shift_tick_ctrl.sv
// shift_tick_ctrl: conditions SW[0]/SW[1]/KEY[1] and runs the IDLE/RUN/PAUSE
// FSM that paces the downstream shift core with a one-cycle step strobe.
//   clk_i     system clock (MAX10_CLK1_50)
//   reset_ni  asynchronous active-low reset
//   bus       shift_tick_ctrl_if.slave: raw switch/key inputs, step_o,
//             dir_o, state_o
// Parameters: DEB_CYCLES (debounce window), STEP_CYCLES (step period).
// Macro SHIFT_TICK_DEBOUNCE_EN enables the debouncers inside debounce_sync.
module shift_tick_ctrl
    import shift_tick_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int unsigned STEP_CYCLES = STEP_CYCLES_DEF
) (
    input logic              clk_i,
    input logic              reset_ni,
    shift_tick_ctrl_if.slave bus
);

    localparam int unsigned   CW      = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STEP_CYCLES - 1);

    logic run_db;
    logic dir_db;
    logic key_db;

    debounce_sync #(.RST_VAL(1'b0), .DEB_CYCLES(DEB_CYCLES)) u_run (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .raw_i    (bus.sw_run_i),
        .db_o     (run_db)
    );

    debounce_sync #(.RST_VAL(1'b0), .DEB_CYCLES(DEB_CYCLES)) u_dir (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .raw_i    (bus.sw_dir_i),
        .db_o     (dir_db)
    );

    debounce_sync #(.RST_VAL(1'b1), .DEB_CYCLES(DEB_CYCLES)) u_key (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .raw_i    (bus.key_pause_ni),
        .db_o     (key_db)
    );

    // Registered falling-edge detect of the debounced key: one-cycle press.
    logic key_db_q;
    logic press_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            key_db_q <= 1'b1;
            press_q  <= 1'b0;
        end else begin
            key_db_q <= key_db;
            press_q  <= key_db_q & ~key_db;
        end
    end

    shift_state_t  state_q;
    logic [CW-1:0] cnt_q;
    logic          step_q;
    logic          dir_q;

    // The prescaler follows the current state, so the RUN->PAUSE edge still
    // counts; any transition into IDLE clears it on the same edge.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            step_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (run_db) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (!run_db) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        if (press_q) state_q <= ST_PAUSE;
                        if (cnt_q == CNT_MAX) begin
                            cnt_q  <= '0;
                            step_q <= 1'b1;
                            dir_q  <= dir_db;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!run_db) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (press_q) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.step_o  = step_q;
    assign bus.dir_o   = dir_q;
    assign bus.state_o = state_q;

endmodule
